// File: rtl/rx78_cart_arbiter.sv
// Cartridge RAM arbiter: buffers HPS download bytes in a small FIFO and interleaves them
// with Z80 read/write requests on the single-port cartridge RAM; tracks image length/validity.
module rx78_cart_arbiter #(
  parameter int unsigned MEM_AW     = 15,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  CART_INDEX = 8'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upload_active,
  input  logic              upload,
  input  logic [7:0]        upload_index,
  input  logic [24:0]       upload_addr,
  input  logic [7:0]        upload_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [MEM_AW-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       cart_len,
  output logic              cart_valid,
  output logic              overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = MEM_AW + 8;
  localparam int unsigned HWM_W = MEM_AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_UWR, S_CWR, S_RD1, S_RD2, S_ACK} state_t;

  state_t            r_state;
  logic [ENT_W-1:0]  r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [HWM_W-1:0]  r_hwm;
  logic              r_active_d;
  logic              r_sess;
  logic              r_end_pend;

  logic              w_match;
  logic              w_in_range;
  logic              w_full;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;
  logic              w_start;
  logic              w_fall;
  logic              w_drained;
  logic              w_end;
  logic [HWM_W-1:0]  w_addr_inc;
  logic [HWM_W-1:0]  w_hwm_base;
  logic [HWM_W-1:0]  w_hwm_next;

  assign w_match    = upload & upload_active & (upload_index == CART_INDEX);
  assign w_in_range = (upload_addr < 25'(1 << MEM_AW));
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push     = w_match & w_in_range & ~w_full;
  assign w_drop     = w_match & ~w_push;
  assign w_pop      = (r_state == S_IDLE) & (r_count != '0);
  assign w_head     = r_fifo[r_rd_ptr];

  assign w_start    = upload_active & ~r_active_d & (upload_index == CART_INDEX);
  assign w_fall     = ~upload_active & r_active_d;
  // FIFO is empty at the end of this cycle, counting a pop of the last entry now
  assign w_drained  = (r_count == '0) | ((r_count == CNT_W'(1)) & w_pop & ~w_push);
  assign w_end      = (r_end_pend | (w_fall & r_sess)) & w_drained;

  assign w_addr_inc = HWM_W'(upload_addr[MEM_AW-1:0]) + HWM_W'(1);
  assign w_hwm_base = w_start ? '0 : r_hwm;
  assign w_hwm_next = (w_push && (w_addr_inc > w_hwm_base)) ? w_addr_inc : w_hwm_base;

  // Upload FIFO storage; contents are don't-care once pointers are reset
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {upload_addr[MEM_AW-1:0], upload_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Session tracking: start clears status, end publishes the high-water mark once drained
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active_d <= 1'b0;
      r_sess     <= 1'b0;
      r_end_pend <= 1'b0;
      r_hwm      <= '0;
      cart_len   <= '0;
      cart_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      r_active_d <= upload_active;
      r_hwm      <= w_hwm_next;
      if (w_start) begin
        r_sess     <= 1'b1;
        r_end_pend <= 1'b0;
        cart_len   <= '0;
        cart_valid <= 1'b0;
        overflow   <= w_drop;
      end else begin
        if (w_drop) overflow <= 1'b1;
        if (w_end) begin
          cart_len   <= 16'(r_hwm);
          cart_valid <= (r_hwm != '0);
          r_end_pend <= 1'b0;
          r_sess     <= 1'b0;
        end else if (w_fall && r_sess) begin
          r_end_pend <= 1'b1;
        end
      end
    end
  end

  // RAM port arbitration; FIFO drain always wins over the CPU in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          mem_we  <= 1'b0;
          cpu_ack <= 1'b0;
          if (r_count != '0) begin
            mem_we    <= 1'b1;
            mem_addr  <= w_head[ENT_W-1:8];
            mem_wdata <= w_head[7:0];
            r_state   <= S_UWR;
          end else if (cpu_req) begin
            mem_addr <= cpu_addr;
            if (cpu_we) begin
              mem_we    <= 1'b1;
              mem_wdata <= cpu_wdata;
              cpu_ack   <= 1'b1;
              r_state   <= S_CWR;
            end else begin
              r_state <= S_RD1;
            end
          end
        end
        S_UWR: begin
          mem_we  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_CWR: begin
          mem_we  <= 1'b0;
          cpu_ack <= 1'b0;
          r_state <= S_IDLE;
        end
        S_RD1: r_state <= S_RD2;
        S_RD2: begin
          cpu_rdata <= mem_rdata;
          cpu_ack   <= 1'b1;
          r_state   <= S_ACK;
        end
        S_ACK: begin
          cpu_ack <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          mem_we  <= 1'b0;
          cpu_ack <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx78_cart_arbiter.sv
// Bench for rx78_cart_arbiter: cycle-level reference model fills write/ack scoreboards,
// a negedge monitor pops and compares RAM writes, acks and the image status outputs.
module tb_rx78_cart_arbiter;

  localparam int unsigned MEM_AW = 15;
  localparam int unsigned DEPTH  = 4;
  localparam logic [7:0]  CART_IDX = 8'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        upload_active = 1'b0;
  logic        upload = 1'b0;
  logic [7:0]  upload_index = 8'd0;
  logic [24:0] upload_addr = '0;
  logic [7:0]  upload_data = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [15:0] cart_len;
  logic        cart_valid;
  logic        overflow;

  rx78_cart_arbiter #(.MEM_AW(MEM_AW), .FIFO_DEPTH(DEPTH), .CART_INDEX(CART_IDX)) dut (
    .clk(clk), .reset(reset), .upload_active(upload_active), .upload(upload),
    .upload_index(upload_index), .upload_addr(upload_addr), .upload_data(upload_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cart_len(cart_len),
    .cart_valid(cart_valid), .overflow(overflow)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int due; logic [14:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int due; logic we; logic [7:0] data; } ack_t;
  typedef struct { logic [14:0] addr; logic [7:0] data; } ent_t;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  wr_t  exp_wr[$];
  ack_t exp_ack[$];
  ent_t m_fifo[$];
  logic [7:0] ram       [0:32767];
  logic [7:0] model_mem [0:32767];
  int   m_busy, m_hwm, exp_len;
  logic m_prev_active, m_sess, m_end_pend, exp_valid, exp_ovf;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_clear();
    exp_wr.delete(); exp_ack.delete(); m_fifo.delete();
    m_busy = 0; m_hwm = 0; exp_len = 0;
    m_prev_active = 1'b0; m_sess = 1'b0; m_end_pend = 1'b0;
    exp_valid = 1'b0; exp_ovf = 1'b0;
  endfunction

  // Synchronous single-port RAM with 1-cycle read latency
  initial forever begin
    @(posedge clk);
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: one iteration per clock, evaluated on the inputs of the cycle just ended
  initial forever begin
    @(posedge clk);
    if (reset) model_clear();
    else begin
      int   start_sz;
      logic match, start, fall;
      ent_t e;
      start_sz = m_fifo.size();
      match = upload && upload_active && (upload_index == CART_IDX);
      start = upload_active && !m_prev_active && (upload_index == CART_IDX);
      fall  = !upload_active && m_prev_active;
      if (start) begin
        exp_len = 0; exp_valid = 1'b0; exp_ovf = 1'b0;
        m_hwm = 0; m_sess = 1'b1; m_end_pend = 1'b0;
      end
      if (m_busy > 0) m_busy--;
      else if (start_sz > 0) begin
        e = m_fifo.pop_front();
        exp_wr.push_back('{cyc + 1, e.addr, e.data});
        m_busy = 1;
      end else if (cpu_req) begin
        if (cpu_we) begin
          exp_wr.push_back('{cyc + 1, cpu_addr, cpu_wdata});
          model_mem[cpu_addr] = cpu_wdata;
          exp_ack.push_back('{cyc + 1, 1'b1, 8'h00});
          m_busy = 1;
        end else begin
          exp_ack.push_back('{cyc + 3, 1'b0, model_mem[cpu_addr]});
          m_busy = 3;
        end
      end
      if (match) begin
        if (upload_addr < 25'h8000 && start_sz < DEPTH) begin
          m_fifo.push_back('{upload_addr[14:0], upload_data});
          model_mem[upload_addr[14:0]] = upload_data;
          if (int'(upload_addr) + 1 > m_hwm) m_hwm = int'(upload_addr) + 1;
        end else exp_ovf = 1'b1;
      end
      if (fall && m_sess) m_end_pend = 1'b1;
      if (m_end_pend && m_fifo.size() == 0) begin
        exp_len = m_hwm; exp_valid = (m_hwm != 0);
        m_end_pend = 1'b0; m_sess = 1'b0;
      end
      m_prev_active = upload_active;
    end
    cyc++;
  end

  // Monitor: pops scoreboards when the DUT presents a write or an ack
  initial forever begin
    wr_t  w;
    ack_t a;
    @(negedge clk);
    if (mem_we) begin
      check("write_expected", 32'(exp_wr.size() > 0), 32'd1);
      if (exp_wr.size() > 0) begin
        w = exp_wr.pop_front();
        check("write_cycle", 32'(cyc), 32'(w.due));
        check("write_addr", 32'(mem_addr), 32'(w.addr));
        check("write_data", 32'(mem_wdata), 32'(w.data));
      end
    end else if (exp_wr.size() > 0 && exp_wr[0].due <= cyc) begin
      check("write_missing", 32'(mem_we), 32'd1);
      void'(exp_wr.pop_front());
    end
    if (cpu_ack) begin
      check("ack_expected", 32'(exp_ack.size() > 0), 32'd1);
      if (exp_ack.size() > 0) begin
        a = exp_ack.pop_front();
        check("ack_cycle", 32'(cyc), 32'(a.due));
        if (!a.we) check("read_data", 32'(cpu_rdata), 32'(a.data));
      end
    end else if (exp_ack.size() > 0 && exp_ack[0].due <= cyc) begin
      check("ack_missing", 32'(cpu_ack), 32'd1);
      void'(exp_ack.pop_front());
    end
    check("cart_len", 32'(cart_len), 32'(exp_len));
    check("cart_valid", 32'(cart_valid), 32'(exp_valid));
    check("overflow", 32'(overflow), 32'(exp_ovf));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic up_byte(input logic [24:0] addr, input logic [7:0] data);
    upload = 1'b1; upload_addr = addr; upload_data = data;
    tick();
    upload = 1'b0;
  endtask

  task automatic session_begin(input logic [7:0] idx);
    upload_index = idx; upload_active = 1'b1;
    tick();
  endtask

  task automatic session_end();
    upload_active = 1'b0;
    repeat (3 * DEPTH + 4) tick();
  endtask

  // Issues one CPU access; exp_lat is cycles from request-visible cycle to ack cycle
  task automatic cpu_access(input logic we, input logic [14:0] addr, input logic [7:0] wd,
                            input int exp_lat, output logic [7:0] rd);
    int lat;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    lat = 0;
    @(negedge clk);
    while (!cpu_ack && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    check("cpu_latency", 32'(lat), 32'(exp_lat));
    rd = cpu_rdata;
    tick();
    cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] rd;
    int nmis;
    for (int i = 0; i < 32768; i++) begin ram[i] = 8'h00; model_mem[i] = 8'h00; end
    model_clear();
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    tick();

    // 8 KiB image, one strobe every 4 cycles
    session_begin(CART_IDX);
    for (int a = 0; a < 'h2000; a++) begin
      up_byte(25'(a), 8'($urandom));
      repeat (3) tick();
    end
    session_end();
    check("load_len", 32'(cart_len), 32'h2000);
    check("load_valid", 32'(cart_valid), 32'd1);
    check("load_overflow", 32'(overflow), 32'd0);
    nmis = 0;
    for (int a = 0; a < 'h2000; a++) if (ram[a] !== model_mem[a]) nmis++;
    check("ram_image_mismatches", 32'(nmis), 32'd0);

    // Foreign index download is ignored
    session_begin(8'd2);
    for (int i = 0; i < 16; i++) begin up_byte(25'(i), 8'($urandom)); tick(); end
    session_end();
    check("idx2_len", 32'(cart_len), 32'h2000);
    check("idx2_valid", 32'(cart_valid), 32'd1);

    // CPU write then read, FIFO idle
    cpu_access(1'b1, 15'h6000, 8'h5A, 1, rd);
    cpu_access(1'b0, 15'h6000, 8'h00, 3, rd);
    check("read_6000", 32'(rd), 32'h5A);

    // Back-to-back strobes overrun the FIFO; only the 8th byte is dropped
    session_begin(CART_IDX);
    for (int i = 0; i < 8; i++) begin
      upload = 1'b1; upload_addr = 25'h100 + 25'(i); upload_data = 8'($urandom);
      tick();
    end
    upload = 1'b0;
    session_end();
    check("burst_overflow", 32'(overflow), 32'd1);
    check("burst_len", 32'(cart_len), 32'h107);

    // Out-of-window address is dropped and does not extend the length
    session_begin(CART_IDX);
    up_byte(25'h0010, 8'hA5); tick();
    up_byte(25'h8000, 8'h3C); tick();
    session_end();
    check("oow_overflow", 32'(overflow), 32'd1);
    check("oow_len", 32'(cart_len), 32'h11);
    check("oow_ram0_untouched", 32'(ram[0] === 8'h3C), 32'd0);

    // One FIFO entry pending at request time delays each ack by 2 cycles
    session_begin(CART_IDX);
    up_byte(25'h0200, 8'h77);
    cpu_access(1'b1, 15'h6001, 8'hC3, 3, rd);
    up_byte(25'h0201, 8'h88);
    cpu_access(1'b0, 15'h6001, 8'h00, 5, rd);
    check("pend_read", 32'(rd), 32'hC3);
    session_end();
    check("pend_len", 32'(cart_len), 32'h202);

    // Randomized upload session with gaps and some out-of-window addresses
    session_begin(CART_IDX);
    for (int i = 0; i < 80; i++) begin
      up_byte(25'($urandom_range(0, 'h9000)), 8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    session_end();

    // Randomized CPU traffic
    for (int i = 0; i < 150; i++) begin
      logic we;
      we = 1'($urandom_range(0, 1));
      cpu_access(we, 15'($urandom_range(0, 'h7FFF)), 8'($urandom), we ? 1 : 3, rd);
    end

    // Reset while a read sits in RD2: no ack, outputs return to reset values
    cpu_access(1'b1, 15'h1234, 8'h5A, 1, rd);
    cpu_access(1'b0, 15'h1234, 8'h00, 3, rd);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
    tick(); tick();
    reset = 1'b1;
    model_clear();
    cpu_req = 1'b0;
    @(negedge clk);
    check("rd2rst_ack", 32'(cpu_ack), 32'd0);
    check("rd2rst_mem_we", 32'(mem_we), 32'd0);
    check("rd2rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rd2rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rd2rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rd2rst_len", 32'(cart_len), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    cpu_access(1'b1, 15'h0042, 8'h99, 1, rd);
    cpu_access(1'b0, 15'h0042, 8'h00, 3, rd);
    check("post_rst_read", 32'(rd), 32'h99);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rx78_cart_arbiter.md
# rx78_cart_arbiter

Shares the single-port cartridge/extension RAM between the HPS download stream (cartridge `.BIN` load) and the Z80 bus inside the RX-78 core. Download bytes are buffered in a small FIFO and written into RAM ahead of CPU accesses. CPU reads and writes are served with a request/acknowledge handshake. The block also tracks the loaded image length and validity, which the core uses to enable the cartridge decode.

## Interface
Parameters:
- `MEM_AW`, 15: RAM address width (32 KiB window).
- `FIFO_DEPTH`, 4: upload FIFO entries; must be a power of 2 and at least 2.
- `CART_INDEX`, 8'd1: `upload_index` value accepted as cartridge data.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `upload_active` in 1: download in progress (level).
- `upload` in 1: one-cycle strobe, byte valid.
- `upload_index` in 8: download target index.
- `upload_addr` in 25: byte address within the image.
- `upload_data` in 8: byte.
- `cpu_req` in 1: CPU access request; held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr` in MEM_AW: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: read data; valid while `cpu_ack` is high.
- `cpu_ack` out 1: one-cycle completion pulse.
- `mem_addr` out MEM_AW: RAM address (registered).
- `mem_we` out 1: RAM write enable (registered).
- `mem_wdata` out 8: RAM write data (registered).
- `mem_rdata` in 8: RAM read data, synchronous, 1-cycle latency.
- `cart_len` out 16: loaded length in bytes, saturating at 2^MEM_AW.
- `cart_valid` out 1: image loaded and non-empty.
- `overflow` out 1: sticky flag, set when an upload byte is dropped.

## Operation
- Accept rule: a byte is accepted when `upload`, `upload_active` and `upload_index == CART_INDEX` are all true, `upload_addr < 2^MEM_AW`, and the FIFO is not full. An accepted byte is pushed as {addr[MEM_AW-1:0], data}.
- Drop rule: a byte with a matching index and `upload_addr ≥ 2^MEM_AW`, or one arriving while the FIFO is full, is dropped and sets `overflow`. Bytes with a non-matching index are ignored silently.
- Session start: on the rising edge of `upload_active` with a matching index, `cart_len`, `cart_valid` and `overflow` clear.
- High-water mark: each accepted byte updates hwm = max(hwm, addr+1), saturating at 2^MEM_AW.
- Session end: on the falling edge of `upload_active`, `cart_len` ← hwm and `cart_valid` ← (hwm ≠ 0). This update is applied only after the FIFO has drained; if entries remain, the update waits until empty.
- FSM states:
  - IDLE: if the FIFO is non-empty, go to UWR (pop). Otherwise, if `cpu_req` is high, go to CWR when `cpu_we`=1, else to RD1. Otherwise stay in IDLE.
  - UWR: `mem_we`=1 with the FIFO entry → IDLE.
  - CWR: `mem_we`=1 with CPU addr/data; `cpu_ack`=1 → IDLE.
  - RD1: `mem_addr`=`cpu_addr`, `mem_we`=0 → RD2.
  - RD2: capture `mem_rdata` into `cpu_rdata` → ACK.
  - ACK: `cpu_ack`=1 → IDLE.
- Priority: the FIFO always wins in IDLE. CPU starvation is bounded because HPS strobes arrive at most once every 2 cycles.
- Simultaneous push and pop in the same cycle are both honoured; the FIFO count is unchanged.
- Reset values: FSM=IDLE, FIFO empty, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_ack`=0, `cpu_rdata`=0, `cart_len`=0, `cart_valid`=0, `overflow`=0, hwm=0.
- Reset mid-operation: any in-flight access is abandoned, no ack is issued, and FIFO contents are discarded.

## Timing
- Upload latency: strobe in cycle N, FIFO empty, FSM idle → `mem_we`=1 with that byte in cycle N+2.
- Upload throughput: 1 byte per 2 cycles sustained (IDLE→UWR→IDLE).
- CPU write: `cpu_req` seen in IDLE at cycle N → `mem_we` and `cpu_ack` both high in cycle N+1 → IDLE at N+2.
- CPU read: `cpu_req` seen at N → RD1 at N+1 → RD2 at N+2 → `cpu_ack` with `cpu_rdata` at N+3.
- The CPU must drop `cpu_req` in the cycle after it sees `cpu_ack`. The FSM never re-grants in the ack cycle.
- `cart_len`/`cart_valid` update 1 cycle after the falling edge of `upload_active` when the FIFO is empty, otherwise 1 cycle after the last pop.

## Test plan
- Load of 8 KiB: addrs 0..0x1FFF at 1 strobe per 4 cycles, index 1 → RAM matches the image; `cart_len`=0x2000; `cart_valid`=1; `overflow`=0.
- Index 2 download of 16 bytes → no `mem_we`, no change to `cart_len`/`cart_valid`.
- Strobes on every cycle, 8 bytes → FIFO fills; dropped bytes set `overflow`=1; exactly the accepted bytes appear in RAM.
- `upload_addr`=0x8000 with index 1 → `overflow`=1, no write; `cart_len` unaffected by that byte.
- CPU write 0x5A to 0x6000, then read 0x6000 → write ack at N+1, read ack at N+3 with `cpu_rdata`=0x5A. With one FIFO entry pending at request time, each ack is delayed by exactly 2 cycles.
- Assert `reset` during RD2 → `cpu_ack` never pulses, all outputs return to reset values, FSM in IDLE on release.
